// File: rtl/prbs_inj_pkg.sv
// Shared types and default widths for the PRBS31 error-injection scheduler.
// Holds the sequencer state encoding and the one-hot mask decode helper.
package prbs_inj_pkg;

    localparam int INT_W_DEF  = 30;
    localparam int BLEN_W_DEF = 8;
    localparam int NB_W_DEF   = 16;
    localparam int CNT_W_DEF  = 12;
    localparam int PRBS_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        INJECT,
        DONE
    } state_t;

    function automatic logic [PRBS_W-1:0] bit_onehot(input logic [4:0] sel);
        logic [PRBS_W-1:0] m;
        m      = '0;
        m[sel] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/inj_interval_timer.sv
// Load/enable up-counter raising tc in the cycle it reaches 'last', then wrapping to zero.
// Latency: tc is combinational on the registered count; no backpressure.
module inj_interval_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc = en && (cnt_q == last);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prbs_inject_scheduler.sv
// Schedules single/burst bit-flip injection into the PRBS31 generator; outputs lag the FSM by one register.
// Latency: start at edge T -> busy from T+1, first pulse at T+1+interval; no backpressure, abort wins.
module prbs_inject_scheduler
    import prbs_inj_pkg::*;
#(
    parameter int INT_W  = INT_W_DEF,
    parameter int BLEN_W = BLEN_W_DEF,
    parameter int NB_W   = NB_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [INT_W-1:0]  cfg_interval,
    input  logic [BLEN_W-1:0] cfg_burst_len,
    input  logic [NB_W-1:0]   cfg_num_bursts,
    input  logic [4:0]        cfg_bit_sel,
    input  logic              cfg_continuous,
    output logic [31:0]       inject_mask,
    output logic              inject_pulse,
    output logic [CNT_W-1:0]  inj_count,
    output logic              busy,
    output logic              done
);

    state_t              state_q, state_d;
    logic [INT_W-1:0]    interval_m1_q, interval_m1_d;
    logic [BLEN_W-1:0]   blen_m1_q, blen_m1_d;
    logic [NB_W-1:0]     num_bursts_q, num_bursts_d;
    logic [NB_W-1:0]     burst_cnt_q, burst_cnt_d;
    logic [4:0]          bit_sel_q, bit_sel_d;
    logic                continuous_q, continuous_d;
    logic [PRBS_W-1:0]   mask_q, mask_d;
    logic                pulse_q, pulse_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    inj_count_q, inj_count_d;

    logic                start_ok;
    logic                injecting;
    logic [NB_W-1:0]     burst_cnt_inc;
    logic                wait_tc;
    logic                burst_tc;

    // Timers are held at zero outside their state so each WAIT/INJECT phase starts from a clean count.
    inj_interval_timer #(.W(INT_W)) u_wait_tmr (
        .clk  (clk),
        .rst  (rst),
        .load (state_q != WAIT),
        .en   (state_q == WAIT),
        .last (interval_m1_q),
        .tc   (wait_tc)
    );

    inj_interval_timer #(.W(BLEN_W)) u_burst_tmr (
        .clk  (clk),
        .rst  (rst),
        .load (state_q != INJECT),
        .en   (state_q == INJECT),
        .last (blen_m1_q),
        .tc   (burst_tc)
    );

    always_comb begin
        start_ok      = (state_q == IDLE) && start && !abort;
        injecting     = (state_q == INJECT) && !abort;
        burst_cnt_inc = burst_cnt_q + NB_W'(1);

        state_d       = state_q;
        interval_m1_d = interval_m1_q;
        blen_m1_d     = blen_m1_q;
        num_bursts_d  = num_bursts_q;
        bit_sel_d     = bit_sel_q;
        continuous_d  = continuous_q;
        burst_cnt_d   = burst_cnt_q;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    // Zero interval/length behave as one cycle.
                    interval_m1_d = (cfg_interval == '0) ? '0 : cfg_interval - INT_W'(1);
                    blen_m1_d     = (cfg_burst_len == '0) ? '0 : cfg_burst_len - BLEN_W'(1);
                    num_bursts_d  = cfg_num_bursts;
                    bit_sel_d     = cfg_bit_sel;
                    continuous_d  = cfg_continuous;
                    burst_cnt_d   = '0;
                    state_d       = (!cfg_continuous && cfg_num_bursts == '0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (wait_tc) begin
                    state_d = INJECT;
                end
            end
            INJECT: begin
                if (burst_tc) begin
                    burst_cnt_d = burst_cnt_inc;
                    if (continuous_q) begin
                        state_d = WAIT;
                    end else if (burst_cnt_inc == num_bursts_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d = IDLE;
        end

        mask_d      = injecting ? bit_onehot(bit_sel_q) : '0;
        pulse_d     = injecting;
        busy_d      = ((state_q == WAIT) || (state_q == INJECT)) && !abort;
        done_d      = (state_q == DONE) && !abort;
        inj_count_d = start_ok  ? '0 :
                      injecting ? inj_count_q + CNT_W'(1) : inj_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            interval_m1_q <= '0;
            blen_m1_q     <= '0;
            num_bursts_q  <= '0;
            bit_sel_q     <= '0;
            continuous_q  <= 1'b0;
            burst_cnt_q   <= '0;
            mask_q        <= '0;
            pulse_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            inj_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            interval_m1_q <= interval_m1_d;
            blen_m1_q     <= blen_m1_d;
            num_bursts_q  <= num_bursts_d;
            bit_sel_q     <= bit_sel_d;
            continuous_q  <= continuous_d;
            burst_cnt_q   <= burst_cnt_d;
            mask_q        <= mask_d;
            pulse_q       <= pulse_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            inj_count_q   <= inj_count_d;
        end
    end

    assign inject_mask  = mask_q;
    assign inject_pulse = pulse_q;
    assign inj_count    = inj_count_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_prbs_inject_scheduler.sv
// Bench for prbs_inject_scheduler: table vectors, hand sequences and random runs against a timing-formula model.
module tb_prbs_inject_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [29:0] cfg_interval;
    logic [7:0]  cfg_burst_len;
    logic [15:0] cfg_num_bursts;
    logic [4:0]  cfg_bit_sel;
    logic        cfg_continuous;
    logic [31:0] inject_mask;
    logic        inject_pulse;
    logic [11:0] inj_count;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [30:0] prbs_st = 31'h1;

    always #5 clk = ~clk;

    prbs_inject_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .cfg_interval   (cfg_interval),
        .cfg_burst_len  (cfg_burst_len),
        .cfg_num_bursts (cfg_num_bursts),
        .cfg_bit_sel    (cfg_bit_sel),
        .cfg_continuous (cfg_continuous),
        .inject_mask    (inject_mask),
        .inject_pulse   (inject_pulse),
        .inj_count      (inj_count),
        .busy           (busy),
        .done           (done)
    );

    typedef struct {
        int i_raw;
        int l_raw;
        int n;
        bit cont;
        int bs;
        int abort_at;
        int ncyc;
        bit perturb;
        int exp_cnt;
        int exp_done;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected outputs k cycles after the start edge, from the burst timing rules:
    // bursts of le cycles, each preceded by ie idle cycles, first idle cycle at k=1.
    function automatic void model(input int ie, input int le, input int n, input bit cont,
                                  input int k, output bit p, output bit b, output bit d);
        int per;
        int m;
        per = ie + le;
        p = 1'b0;
        b = 1'b0;
        d = 1'b0;
        if (k >= 1) begin
            b = cont || (k <= n * per);
            d = !cont && (k == 1 + n * per);
            m = k - 1 - ie;
            if (m >= 0) begin
                p = ((m % per) < le) && (cont || (m / per) < n);
            end
        end
    endfunction

    task automatic prbs_step(output logic [31:0] w);
        logic fb;
        for (int i = 0; i < 32; i++) begin
            fb      = prbs_st[30] ^ prbs_st[27];
            prbs_st = {prbs_st[29:0], fb};
            w[i]    = fb;
        end
    endtask

    task automatic run_seq(input int i_raw, input int l_raw, input int n, input bit cont,
                           input int bs, input int abort_at, input int ncyc, input bit perturb,
                           input string tag, output int cnt_out, output int done_out);
        int          ie, le, err_bits, bad_pos, pulses;
        bit          ep, eb, ed;
        logic [11:0] cnt_exp;
        logic [31:0] exp_mask, word, rx, errv, one;
        ie = (i_raw == 0) ? 1 : i_raw;
        le = (l_raw == 0) ? 1 : l_raw;
        one = 32'h1;
        @(negedge clk);
        cfg_interval   = 30'(i_raw);
        cfg_burst_len  = 8'(l_raw);
        cfg_num_bursts = 16'(n);
        cfg_bit_sel    = 5'(bs);
        cfg_continuous = cont;
        start          = 1'b1;
        abort          = 1'b0;
        cnt_exp = '0;
        done_out = 0;
        err_bits = 0;
        bad_pos = 0;
        pulses = 0;
        for (int k = 0; k <= ncyc; k++) begin
            @(negedge clk);
            model(ie, le, n, cont, k, ep, eb, ed);
            if (abort_at >= 0 && k >= abort_at) begin
                ep = 1'b0;
                eb = 1'b0;
                ed = 1'b0;
            end
            if (ep) begin
                cnt_exp = cnt_exp + 12'd1;
                pulses++;
            end
            exp_mask = ep ? (one << bs) : 32'h0;
            check($sformatf("%s k=%0d {mask,pulse,busy,done,count}", tag, k),
                  {15'h0, inject_mask, inject_pulse, busy, done, inj_count},
                  {15'h0, exp_mask, ep, eb, ed, cnt_exp});
            done_out += int'(done);
            // Transmitted word carries the mask; the receiver compares against a clean PRBS31 copy.
            prbs_step(word);
            rx   = word ^ inject_mask;
            errv = rx ^ word;
            err_bits += $countones(errv);
            if (errv != 32'h0 && errv != (one << bs)) bad_pos++;
            start = 1'b0;
            if (perturb && k == 1) begin
                start          = 1'b1;
                cfg_interval   = 30'($urandom);
                cfg_burst_len  = 8'($urandom);
                cfg_num_bursts = 16'($urandom);
                cfg_bit_sel    = 5'($urandom);
                cfg_continuous = 1'($urandom);
            end
            abort = (abort_at >= 0) && (k + 1 == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
        check({tag, " prbs error bits"}, 64'(err_bits), 64'(pulses));
        check({tag, " prbs wrong error position"}, 64'(bad_pos), 64'd0);
        cnt_out = int'(inj_count);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        int cnt_o, done_o, last_cnt;
        int ri, rl, rn, rp, ab, nc;
        bit rc, pt;

        //            i   l  n  cont bs  abort  ncyc  pert cnt done
        vecs[0] = '{  4,  1, 1, 1'b0,  0,    -1,    10, 1'b0,  1, 1};
        vecs[1] = '{  3,  2, 3, 1'b0, 31,    -1,    19, 1'b1,  6, 1};
        vecs[2] = '{  0,  0, 0, 1'b0,  3,    -1,     4, 1'b0,  0, 1};
        vecs[3] = '{  0,  0, 2, 1'b0,  7,    -1,     8, 1'b0,  2, 1};
        vecs[4] = '{  2,  3, 2, 1'b0, 13,    -1,    14, 1'b1,  6, 1};
        vecs[5] = '{  5,  2, 4, 1'b0, 20,     9,    40, 1'b0,  2, 0};
        vecs[6] = '{ 20,  3, 2, 1'b0, 16,    -1,    50, 1'b0,  6, 1};
        vecs[7] = '{  1,  1, 0, 1'b1,  5, 10000, 10004, 1'b0, 903, 0};
        vecs[8] = '{  0,  5, 1, 1'b0,  1,    -1,    10, 1'b1,  5, 1};
        vecs[9] = '{  1,  1, 1, 1'b0,  9,     3,     6, 1'b0,  1, 0};

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg_interval = '0;
        cfg_burst_len = '0;
        cfg_num_bursts = '0;
        cfg_bit_sel = '0;
        cfg_continuous = 1'b0;
        repeat (3) @(negedge clk);
        check("reset state", {15'h0, inject_mask, inject_pulse, busy, done, inj_count}, 64'h0);
        rst = 1'b0;

        // Reset asserted while injecting clears everything on the first reset edge.
        @(negedge clk);
        cfg_interval = 30'd1;
        cfg_burst_len = 8'd5;
        cfg_num_bursts = 16'd1;
        cfg_bit_sel = 5'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-reset injecting mask", {32'h0, inject_mask}, 64'h10);
        rst = 1'b1;
        @(negedge clk);
        check("reset mid-inject", {15'h0, inject_mask, inject_pulse, busy, done, inj_count}, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("idle after reset c%0d", i),
                  {15'h0, inject_mask, inject_pulse, busy, done, inj_count}, 64'h0);
        end

        for (int v = 0; v < 10; v++) begin
            run_seq(vecs[v].i_raw, vecs[v].l_raw, vecs[v].n, vecs[v].cont, vecs[v].bs,
                    vecs[v].abort_at, vecs[v].ncyc, vecs[v].perturb,
                    $sformatf("vec%0d", v), cnt_o, done_o);
            check($sformatf("vec%0d final inj_count", v), 64'(cnt_o), 64'(vecs[v].exp_cnt));
            check($sformatf("vec%0d done pulses", v), 64'(done_o), 64'(vecs[v].exp_done));
        end
        last_cnt = vecs[9].exp_cnt;

        // Start and abort together: start is dropped, count is not cleared.
        @(negedge clk);
        cfg_interval = 30'd1;
        cfg_burst_len = 8'd1;
        cfg_num_bursts = 16'd3;
        cfg_continuous = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("start+abort stays idle c%0d", i),
                  {15'h0, inject_mask, inject_pulse, busy, done, inj_count}, 64'(last_cnt));
            @(negedge clk);
        end

        for (int r = 0; r < 30; r++) begin
            ri = int'($urandom_range(0, 6));
            rl = int'($urandom_range(0, 4));
            rn = int'($urandom_range(0, 4));
            rc = ($urandom_range(0, 4) == 0);
            rp = ((ri == 0) ? 1 : ri) + ((rl == 0) ? 1 : rl);
            if (rc) begin
                ab = int'($urandom_range(3, 40));
                nc = ab + 3;
            end else begin
                ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, rn * rp + 2)) : -1;
                nc = rn * rp + 4;
            end
            pt = ($urandom_range(0, 1) == 1) && (rn >= 1 || rc) && (ab < 0 || ab >= 2);
            run_seq(ri, rl, rn, rc, int'($urandom_range(0, 31)), ab, nc, pt,
                    $sformatf("rnd%0d", r), cnt_o, done_o);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
